clkgen_prog: RTL and testbench
==============================

# clkgen_prog

Runtime frequency controller for up to N_CHANNELS DCM_CLKGEN primitives and their downstream PLL_BASE/BUFG chains. It accepts M/D requests from the host-command logic and shifts them into the selected DCM_CLKGEN over the PROG* serial port, one channel at a time. It then waits for PROGDONE and LOCKED and sequences the PLL reset, so each application clock (for example PKT_COMM_CLK) is re-tuned without a bitstream rebuild. It sits in the clocking wrapper, clocked by the always-running IFCLK domain.

## Interface
Parameters:
- N_CHANNELS, 2: number of DCM_CLKGEN/PLL chains controlled (1-8).
- CH_W, 1: width of the channel index; must satisfy 2**CH_W >= N_CHANNELS.
- TIMEOUT, 65535: maximum cycles spent in WAIT_DONE or WAIT_LOCK before failure.
- PLL_RST_CYCLES, 16: cycles PLL_RST stays asserted after LOCKED is seen.

Ports:
- CLK, in, 1: single block clock; the parent also ties every DCM's PROGCLK to CLK.
- RESET_N, in, 1: reset, synchronous to CLK, active-low.
- REQ_VALID, in, 1: request present.
- REQ_READY, out, 1: block accepts a request this cycle.
- REQ_CH, in, CH_W: target channel.
- REQ_M1, in, 8: multiplier M minus 1.
- REQ_D1, in, 8: divider D minus 1.
- PROGEN, out, N_CHANNELS: per-channel DCM_CLKGEN PROGEN.
- PROGDATA, out, N_CHANNELS: per-channel DCM_CLKGEN PROGDATA.
- PROGDONE, in, N_CHANNELS: per-channel DCM_CLKGEN PROGDONE; asynchronous.
- LOCKED, in, N_CHANNELS: per-channel DCM_CLKGEN LOCKED; asynchronous.
- PLL_RST, out, N_CHANNELS: per-channel PLL_BASE RST.
- CH_READY, out, N_CHANNELS: the channel's clock is programmed, locked and out of reset.
- CH_FAIL, out, N_CHANNELS: the last operation on the channel timed out; sticky until that channel is next programmed.
- ERR, out, 1: one-cycle pulse on a rejected request or a timeout.

## Operation
- PROGDONE and LOCKED each pass through a 2-flop synchroniser; all decisions use the synchronised copies.
- All outputs are registered.
- The FSM serves one channel at a time, tracked by an internal register CUR.
- States: INIT, IDLE, SHIFT_D, GAP1, SHIFT_M, GAP2, GO, WAIT_DONE, WAIT_LOCK, PLL_HOLD.

INIT (entered from reset):
- Scans channels 0..N_CHANNELS-1 in order.
- For each channel, waits for its synchronised LOCKED, bounded by TIMEOUT.
- Then holds PLL_HOLD for PLL_RST_CYCLES, deasserts that PLL_RST and sets CH_READY.
- A timeout sets CH_FAIL, pulses ERR and moves on to the next channel.
- After the last channel the FSM goes to IDLE.

IDLE:
- REQ_READY=1. A request is accepted on REQ_VALID & REQ_READY.
- Rejection: if REQ_M1 == 0 (M < 2) or REQ_CH >= N_CHANNELS, the request is consumed, ERR pulses, and no state changes.
- Otherwise CUR <= REQ_CH and M1/D1 are latched. The next cycle asserts PLL_RST[CUR], clears CH_READY[CUR] and CH_FAIL[CUR], and enters SHIFT_D.

SHIFT_D:
- 10 cycles with PROGEN[CUR]=1.
- PROGDATA sequence: 1, 0, then D1[0..7], LSB first.

GAP1 and GAP2:
- 2 cycles each with PROGEN=0 and PROGDATA=0.

SHIFT_M:
- 10 cycles with PROGEN[CUR]=1.
- PROGDATA sequence: 1, 1, then M1[0..7], LSB first.

GO:
- 1 cycle with PROGEN[CUR]=1 and PROGDATA=0.

WAIT_DONE:
- Waits for synchronised PROGDONE[CUR]=1, then goes to WAIT_LOCK.

WAIT_LOCK:
- Waits for synchronised LOCKED[CUR]=1, then goes to PLL_HOLD.

PLL_HOLD:
- Counts PLL_RST_CYCLES, then deasserts PLL_RST[CUR], sets CH_READY[CUR] and returns to IDLE.

Timeout handling:
- The timeout counter clears on entry to WAIT_DONE and to WAIT_LOCK.
- Reaching TIMEOUT: CH_FAIL[CUR]=1, ERR pulses, PLL_RST[CUR] stays 1, CH_READY[CUR] stays 0, and the FSM returns to IDLE.

Channel isolation:
- Channels other than CUR keep their PLL_RST, CH_READY and CH_FAIL unchanged throughout.
- PROGEN and PROGDATA of non-CUR channels stay 0.

## Timing
Reset values (while RESET_N=0 at a CLK edge):
- PROGEN=0, PROGDATA=0, ERR=0, REQ_READY=0.
- PLL_RST all 1s, CH_READY=0, CH_FAIL=0.
- FSM in INIT with channel index 0; all counters cleared.

Programming sequence, with the request accepted at edge 0:
- PROGEN[CUR] is high in cycles 1-10, 13-22 and 25.
- WAIT_DONE starts at cycle 26.
- The minimum accept-to-CH_READY time is 26 + 2 (PROGDONE sync) + 2 (LOCKED sync) + PLL_RST_CYCLES + 1.

Handshake:
- REQ_READY is 1 only in IDLE, and deasserts the cycle after acceptance.
- REQ_VALID with REQ_READY=0 has no effect; the requester holds it.

Boundary conditions:
- LOCKED dropping during PLL_HOLD restarts WAIT_LOCK with its timeout counter cleared.
- LOCKED dropping on a CH_READY channel while idle clears CH_READY and reasserts PLL_RST; the following LOCKED rise re-runs PLL_HOLD for that channel, but only when the FSM is idle.
- A stale PROGDONE=1 present on entry to WAIT_DONE is honoured.
- RESET_N low in any state aborts immediately to the reset values; a partially shifted word is discarded, and PROGEN=0 on the next cycle guarantees DCM command framing.

## Test plan
1. Reset with the LOCKED model high after 100 cycles, PLL_RST_CYCLES=16 → PLL_RST[0] falls at about cycle 118, then channel 1 follows; both CH_READY=1; REQ_READY=1 afterwards.
2. Request ch1, M1=29, D1=3 → PROGEN[1] high in cycles 1-10/13-22/25; PROGDATA[1] = 1,0,1,1,0,0,0,0,0,0 then 1,1,1,0,1,1,1,0,0,0; PROGEN[0] stays 0.
3. Request with M1=0 → ERR pulses one cycle, no PROGEN activity, CH_READY unchanged, REQ_READY stays 1.
4. PROGDONE model never rises, TIMEOUT=100 → ERR at 100 cycles after WAIT_DONE entry, CH_FAIL[ch]=1, PLL_RST[ch]=1; a subsequent valid request clears CH_FAIL.
5. RESET_N low in cycle 15 of a program sequence → next cycle PROGEN=0 and all PLL_RST=1; INIT reruns.
6. LOCKED[0] deasserted for 5 cycles during PLL_HOLD → PLL_RST held, and PLL_HOLD restarts a full 16 cycles after LOCKED returns.

Source files
------------

// File: rtl/clkgen_prog_if.sv
// Request channel into the DCM_CLKGEN runtime frequency controller.
//   REQ_VALID : request present (held by the requester until accepted)
//   REQ_READY : controller accepts a request this cycle
//   REQ_CH    : target DCM/PLL channel
//   REQ_M1    : multiplier M minus 1
//   REQ_D1    : divider D minus 1
// master = host-command logic, slave = clkgen_prog.
interface clkgen_prog_if #(
  parameter int CH_W = 1
);
  logic            REQ_VALID;
  logic            REQ_READY;
  logic [CH_W-1:0] REQ_CH;
  logic [7:0]      REQ_M1;
  logic [7:0]      REQ_D1;

  modport master (output REQ_VALID, REQ_CH, REQ_M1, REQ_D1, input REQ_READY);
  modport slave  (input REQ_VALID, REQ_CH, REQ_M1, REQ_D1, output REQ_READY);
endinterface

// File: rtl/clkgen_prog.sv
// Runtime frequency controller for N_CHANNELS DCM_CLKGEN + PLL_BASE chains.
// Brings every chain up after reset (wait LOCKED, hold PLL reset), then
// serves M/D requests one channel at a time: shifts the D and M words into
// the DCM over PROGEN/PROGDATA, issues GO, waits PROGDONE and LOCKED and
// sequences the PLL reset before reporting the channel ready.
// Ports:
//   CLK, RESET_N   : block clock (also every DCM's PROGCLK), sync active-low reset
//   req            : request channel (clkgen_prog_if.slave)
//   PROGEN/PROGDATA: per-channel DCM serial programming port
//   PROGDONE/LOCKED: per-channel DCM status, asynchronous
//   PLL_RST        : per-channel PLL_BASE reset
//   CH_READY       : channel programmed, locked and out of reset
//   CH_FAIL        : last operation on the channel timed out (sticky)
//   ERR            : one-cycle pulse on a rejected request or a timeout
module clkgen_prog #(
  parameter int N_CHANNELS     = 2,
  parameter int CH_W           = 1,
  parameter int TIMEOUT        = 65535,
  parameter int PLL_RST_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  clkgen_prog_if.slave          req,
  output logic [N_CHANNELS-1:0] PROGEN,
  output logic [N_CHANNELS-1:0] PROGDATA,
  input  logic [N_CHANNELS-1:0] PROGDONE,
  input  logic [N_CHANNELS-1:0] LOCKED,
  output logic [N_CHANNELS-1:0] PLL_RST,
  output logic [N_CHANNELS-1:0] CH_READY,
  output logic [N_CHANNELS-1:0] CH_FAIL,
  output logic                  ERR
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(PLL_RST_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(PLL_RST_CYCLES - 1);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N_CHANNELS - 1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_SHIFT_D, S_GAP1, S_SHIFT_M, S_GAP2,
    S_GO, S_WAIT_DONE, S_WAIT_LOCK, S_PLL_HOLD
  } state_t;

  state_t                  state;
  logic [CH_W-1:0]         cur;
  logic [7:0]              m1_q, d1_q;
  logic [3:0]              bit_cnt;
  logic [TW-1:0]           tmo;
  logic [HW-1:0]           hold_cnt;
  logic                    init_mode;   // PLL_HOLD/lock loss belong to the power-up scan
  logic                    rdy_q;
  logic [N_CHANNELS-1:0]   relock_pend; // channel lost lock while ready, waits for relock
  logic [N_CHANNELS-1:0]   done_m, done_s, lock_m, lock_s;

  logic                    relock_hit;
  logic [CH_W-1:0]         relock_ch;

  assign req.REQ_READY = rdy_q;

  // DCM command word: two header bits then the 8-bit payload, LSB first.
  // Header is 1,0 for D and 1,1 for M.
  function automatic logic shift_bit(input logic hdr1, input logic [7:0] w,
                                     input logic [3:0] idx);
    logic [2:0] k;
    k = 3'(idx - 4'd2);
    case (idx)
      4'd0:    shift_bit = 1'b1;
      4'd1:    shift_bit = hdr1;
      default: shift_bit = w[k];
    endcase
  endfunction

  // Lowest-numbered channel that is waiting to relock and has LOCKED back.
  always_comb begin
    relock_hit = 1'b0;
    relock_ch  = '0;
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (relock_pend[i] && lock_s[i]) begin
        relock_hit = 1'b1;
        relock_ch  = CH_W'(i);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state       <= S_INIT;
      cur         <= '0;
      m1_q        <= '0;
      d1_q        <= '0;
      bit_cnt     <= '0;
      tmo         <= '0;
      hold_cnt    <= '0;
      init_mode   <= 1'b1;
      rdy_q       <= 1'b0;
      relock_pend <= '0;
      done_m      <= '0;
      done_s      <= '0;
      lock_m      <= '0;
      lock_s      <= '0;
      PROGEN      <= '0;
      PROGDATA    <= '0;
      PLL_RST     <= '1;
      CH_READY    <= '0;
      CH_FAIL     <= '0;
      ERR         <= 1'b0;
    end else begin
      done_m   <= PROGDONE;
      done_s   <= done_m;
      lock_m   <= LOCKED;
      lock_s   <= lock_m;
      PROGEN   <= '0;
      PROGDATA <= '0;
      ERR      <= 1'b0;

      case (state)
        // Power-up scan: wait for each channel's LOCKED in turn.
        S_INIT: begin
          if (lock_s[cur]) begin
            hold_cnt <= '0;
            state    <= S_PLL_HOLD;
          end else if (tmo == TMO_LAST) begin
            CH_FAIL[cur] <= 1'b1;
            ERR          <= 1'b1;
            tmo          <= '0;
            if (cur == LAST_CH) begin
              init_mode <= 1'b0;
              rdy_q     <= 1'b1;
              state     <= S_IDLE;
            end else begin
              cur <= cur + 1'b1;
            end
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        S_IDLE: begin
          // A ready channel that loses lock goes back into PLL reset and is
          // re-held once LOCKED returns.
          for (int i = 0; i < N_CHANNELS; i++) begin
            if (CH_READY[i] && !lock_s[i]) begin
              CH_READY[i]    <= 1'b0;
              PLL_RST[i]     <= 1'b1;
              relock_pend[i] <= 1'b1;
            end
          end
          if (req.REQ_VALID) begin
            if (req.REQ_M1 == 8'd0 || 32'(req.REQ_CH) >= N_CHANNELS) begin
              ERR <= 1'b1;
            end else begin
              cur     <= req.REQ_CH;
              m1_q    <= req.REQ_M1;
              d1_q    <= req.REQ_D1;
              bit_cnt <= '0;
              rdy_q   <= 1'b0;
              state   <= S_SHIFT_D;
            end
          end else if (relock_hit) begin
            cur                    <= relock_ch;
            relock_pend[relock_ch] <= 1'b0;
            hold_cnt               <= '0;
            rdy_q                  <= 1'b0;
            state                  <= S_PLL_HOLD;
          end
        end

        S_SHIFT_D: begin
          PROGEN[cur]   <= 1'b1;
          PROGDATA[cur] <= shift_bit(1'b0, d1_q, bit_cnt);
          if (bit_cnt == 4'd0) begin
            PLL_RST[cur]     <= 1'b1;
            CH_READY[cur]    <= 1'b0;
            CH_FAIL[cur]     <= 1'b0;
            relock_pend[cur] <= 1'b0;
          end
          if (bit_cnt == 4'd9) begin
            bit_cnt <= '0;
            state   <= S_GAP1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        S_GAP1: begin
          if (bit_cnt == 4'd1) begin
            bit_cnt <= '0;
            state   <= S_SHIFT_M;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        S_SHIFT_M: begin
          PROGEN[cur]   <= 1'b1;
          PROGDATA[cur] <= shift_bit(1'b1, m1_q, bit_cnt);
          if (bit_cnt == 4'd9) begin
            bit_cnt <= '0;
            state   <= S_GAP2;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        S_GAP2: begin
          if (bit_cnt == 4'd1) begin
            bit_cnt <= '0;
            state   <= S_GO;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        // GO is a single PROGEN pulse with PROGDATA low.
        S_GO: begin
          PROGEN[cur] <= 1'b1;
          tmo         <= '0;
          state       <= S_WAIT_DONE;
        end

        // A PROGDONE already high on entry counts.
        S_WAIT_DONE: begin
          if (done_s[cur]) begin
            tmo   <= '0;
            state <= S_WAIT_LOCK;
          end else if (tmo == TMO_LAST) begin
            CH_FAIL[cur] <= 1'b1;
            ERR          <= 1'b1;
            rdy_q        <= 1'b1;
            state        <= S_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (lock_s[cur]) begin
            hold_cnt <= '0;
            state    <= S_PLL_HOLD;
          end else if (tmo == TMO_LAST) begin
            CH_FAIL[cur] <= 1'b1;
            ERR          <= 1'b1;
            rdy_q        <= 1'b1;
            state        <= S_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        // PLL_RST stays high for PLL_RST_CYCLES of continuous lock; a lock
        // drop sends us back to waiting with a fresh timeout.
        S_PLL_HOLD: begin
          if (!lock_s[cur]) begin
            tmo   <= '0;
            state <= init_mode ? S_INIT : S_WAIT_LOCK;
          end else if (hold_cnt == HOLD_LAST) begin
            PLL_RST[cur]  <= 1'b0;
            CH_READY[cur] <= 1'b1;
            if (init_mode && cur != LAST_CH) begin
              cur   <= cur + 1'b1;
              tmo   <= '0;
              state <= S_INIT;
            end else begin
              init_mode <= 1'b0;
              rdy_q     <= 1'b1;
              state     <= S_IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_clkgen_prog.sv
// Directed bench for clkgen_prog: power-up scan, programming waveform,
// rejection, timeout, lock loss in PLL_HOLD and in idle, reset abort.
module tb_clkgen_prog;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] progen, progdata, progdone, locked, pll_rst, ch_ready, ch_fail;
  logic         err;
  int           n_chk = 0;
  int           n_err = 0;

  clkgen_prog_if #(.CH_W(1)) rif ();

  always #5 clk = ~clk;

  clkgen_prog #(
    .N_CHANNELS(N), .CH_W(1), .TIMEOUT(100), .PLL_RST_CYCLES(16)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .req(rif),
    .PROGEN(progen), .PROGDATA(progdata), .PROGDONE(progdone), .LOCKED(locked),
    .PLL_RST(pll_rst), .CH_READY(ch_ready), .CH_FAIL(ch_fail), .ERR(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle; returns at the negedge after the
  // accepting edge (edge 0).
  task automatic send(input logic ch, input logic [7:0] m1, input logic [7:0] d1);
    rif.REQ_CH    = ch;
    rif.REQ_M1    = m1;
    rif.REQ_D1    = d1;
    rif.REQ_VALID = 1'b1;
    @(negedge clk);
    rif.REQ_VALID = 1'b0;
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [31:0] pe1, pd1, exp_pe, exp_pd;
    logic pe0, held;
    int dbits [10] = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    int mbits [10] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0};

    rif.REQ_VALID = 1'b0;
    rif.REQ_CH    = 1'b0;
    rif.REQ_M1    = 8'd0;
    rif.REQ_D1    = 8'd0;
    progdone      = '0;
    locked        = '0;

    // Reset values
    cyc(3);
    chk("rst_progen", progen, 0);
    chk("rst_progdata", progdata, 0);
    chk("rst_pll_rst", pll_rst, 2'b11);
    chk("rst_ch_ready", ch_ready, 0);
    chk("rst_ch_fail", ch_fail, 0);
    chk("rst_err", err, 0);
    chk("rst_req_ready", rif.REQ_READY, 0);

    // Power-up scan: LOCKED rises 40 cycles after reset release
    rst_n = 1'b1;
    cyc(40);
    locked = 2'b11;
    n = 0;
    while (pll_rst[0] && n < 200) begin @(negedge clk); n++; end
    chk("init_rst0_lat", n, 19);
    n = 0;
    while (pll_rst[1] && n < 200) begin @(negedge clk); n++; end
    chk("init_rst1_gap", n, 17);
    chk("init_ready", ch_ready, 2'b11);
    chk("init_fail", ch_fail, 0);
    chk("init_req_ready", rif.REQ_READY, 1);

    // Program ch1, M1=29, D1=3: capture the serial waveform for cycles 1..26
    exp_pe = '0;
    exp_pd = '0;
    for (int c = 1; c <= 10; c++) begin exp_pe[c] = 1'b1; exp_pd[c] = dbits[c-1][0]; end
    for (int c = 13; c <= 22; c++) begin exp_pe[c] = 1'b1; exp_pd[c] = mbits[c-13][0]; end
    exp_pe[25] = 1'b1;
    pe1 = '0;
    pd1 = '0;
    pe0 = 1'b0;
    send(1'b1, 8'd29, 8'd3);
    chk("busy_req_ready", rif.REQ_READY, 0);
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      pe1[c] = progen[1];
      pd1[c] = progdata[1];
      pe0    = pe0 | progen[0] | progdata[0];
      if (c == 1) begin
        chk("prog_pll_rst1", pll_rst, 2'b10);
        chk("prog_ch_ready", ch_ready, 2'b01);
      end
    end
    chk("prog_progen1", pe1, exp_pe);
    chk("prog_progdata1", pd1, exp_pd);
    chk("prog_ch0_quiet", pe0, 0);
    progdone[1] = 1'b1;
    n = 0;
    while (!ch_ready[1] && n < 60) begin @(negedge clk); n++; end
    chk("prog_done_ready", ch_ready, 2'b11);
    chk("prog_done_rst", pll_rst, 2'b00);
    chk("prog_done_req_ready", rif.REQ_READY, 1);
    progdone = '0;
    cyc(2);

    // Rejected request: M1=0
    send(1'b0, 8'd0, 8'd5);
    chk("rej_err", err, 1);
    chk("rej_req_ready", rif.REQ_READY, 1);
    cyc(1);
    chk("rej_err_pulse", err, 0);
    pe0 = 1'b0;
    for (int c = 0; c < 12; c++) begin @(negedge clk); pe0 = pe0 | (|progen); end
    chk("rej_no_progen", pe0, 0);
    chk("rej_ready_kept", ch_ready, 2'b11);

    // PROGDONE never rises: timeout on ch0
    send(1'b0, 8'd9, 8'd1);
    n = 0;
    while (!err && n < 300) begin @(negedge clk); n++; end
    chk("tmo_lat", n, 125);
    chk("tmo_fail", ch_fail, 2'b01);
    chk("tmo_pll_rst", pll_rst, 2'b01);
    chk("tmo_ready", ch_ready, 2'b10);
    chk("tmo_req_ready", rif.REQ_READY, 1);

    // Stale PROGDONE honoured; new request clears CH_FAIL
    progdone[0] = 1'b1;
    cyc(3);
    send(1'b0, 8'd9, 8'd1);
    cyc(1);
    chk("refail_clear", ch_fail, 0);
    n = 0;
    while (!ch_ready[0] && n < 80) begin @(negedge clk); n++; end
    chk("stale_done_ready", ch_ready, 2'b11);
    cyc(2);

    // LOCKED[0] drops for 5 cycles during PLL_HOLD
    send(1'b0, 8'd4, 8'd2);
    cyc(30);
    locked[0] = 1'b0;
    held = 1'b1;
    for (int c = 0; c < 5; c++) begin @(negedge clk); held = held & pll_rst[0]; end
    locked[0] = 1'b1;
    n = 0;
    while (pll_rst[0] && n < 100) begin @(negedge clk); n++; end
    chk("hold_drop_held", held, 1);
    chk("hold_restart_lat", n, 19);
    chk("hold_iso_ready1", ch_ready[1], 1);
    chk("hold_iso_rst1", pll_rst[1], 0);
    cyc(2);

    // LOCKED[1] drops while idle, then returns
    locked[1] = 1'b0;
    cyc(3);
    chk("idle_drop_ready", ch_ready, 2'b01);
    chk("idle_drop_rst", pll_rst, 2'b10);
    locked[1] = 1'b1;
    n = 0;
    while (!ch_ready[1] && n < 60) begin @(negedge clk); n++; end
    chk("idle_relock_lat", n, 19);
    chk("idle_relock_rst", pll_rst, 2'b00);
    cyc(2);

    // Reset in cycle 15 of a programming sequence
    send(1'b1, 8'd29, 8'd3);
    cyc(14);
    rst_n = 1'b0;
    cyc(1);
    chk("abort_progen", progen, 0);
    chk("abort_pll_rst", pll_rst, 2'b11);
    chk("abort_ready", ch_ready, 0);
    chk("abort_req_ready", rif.REQ_READY, 0);
    cyc(2);
    rst_n = 1'b1;
    n = 0;
    while (!rif.REQ_READY && n < 300) begin @(negedge clk); n++; end
    chk("reinit_req_ready", rif.REQ_READY, 1);
    chk("reinit_ready", ch_ready, 2'b11);
    chk("reinit_fail", ch_fail, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
